rotate_sequencer: RTL and testbench
===================================

# rotate_sequencer

Upstream control stage for the six-digit rotating 7-segment message display. Generates the 3-bit rotation select that drives the six 3-bit 6-to-1 word multiplexers, replacing hand-held KEY selection with a timed, debounced, user-controllable rotation. Outputs feed the mux select inputs directly; the downstream mux and 7-segment decoders are unchanged.

## Interface
- TICK_DIV, 50000000: clock cycles per automatic advance (1 Hz at 50 MHz); legal range ≥ 2.
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required to accept a key level change (10 ms); legal range ≥ 1.
- CLOCK_50  in  1  system clock; single clock domain.
- resetn  in  1  asynchronous, active-low reset.
- key_pause_n  in  1  raw push button, active-low; a press toggles run/pause.
- key_step_n  in  1  raw push button, active-low; a press advances one position while paused.
- key_dir_n  in  1  raw push button, active-low; a press toggles direction.
- rot_sel  out  3  current rotation index, drives the mux select.
- tick  out  1  one-cycle pulse, high in the cycle `rot_sel` takes a new value.
- running  out  1  1 = RUN, 0 = PAUSE.
- dir  out  1  0 = forward (increment), 1 = backward (decrement).

## Operation
- Reset values: `rot_sel`=0, `tick`=0, `running`=1, `dir`=0. The prescaler and debounce counters are 0. Every debounced key level is "released", and edge detectors are cleared.
- Key path per button:
  - 2-flop synchronizer.
  - Debouncer: a counter increments each cycle in which the synchronized level differs from the debounced level, and clears otherwise (any bounce restarts it). When the counter reaches DEBOUNCE_CYCLES, the debounced level flips.
  - Press event: a one-cycle pulse on the debounced high→low transition. Releases generate no event.
- FSM states:
  - RUN: the prescaler counts 0..TICK_DIV-1. At TICK_DIV-1 it returns to 0, and `rot_sel` advances one position in direction `dir` with `tick`=1. A pause event moves to PAUSE. Step events are ignored.
  - PAUSE: the prescaler is held at 0. A step event advances `rot_sel` one position with `tick`=1. A pause event returns to RUN, and the first automatic advance comes a full TICK_DIV cycles later.
- A dir event toggles `dir` in either state.
- Position arithmetic is modulo N, with N=6 (positions 0..5). Forward wraps 5→0; backward wraps 0→5. `rot_sel` never leaves 0..N-1.
- Simultaneous events in one cycle:
  - Dir + step: the toggle is applied first, and the step uses the new direction.
  - Dir + prescaler wrap: the advance uses the new direction.
  - Pause event + prescaler wrap in RUN: the advance happens, then the FSM enters PAUSE.
  - Step is ignored in RUN even if coincident with a pause event.
- Reset asserted mid-operation clears all state immediately. After release, operation restarts from the reset values; a key held through reset is reported as a press only after a full debounce.

## Timing
- All outputs are registered; no combinational input→output path.
- Key latency:
  - A press held stable from the first edge that samples it low takes effect on the outputs exactly DEBOUNCE_CYCLES+3 rising edges later (2 sync, DEBOUNCE_CYCLES debounce, 1 action register).
- Automatic advance period: exactly TICK_DIV cycles between `tick` pulses in RUN.
- `tick` is never high for two consecutive cycles, because TICK_DIV ≥ 2 and a step press requires a debounce.

## Configuration
- ROTATE_SEQ_BLANK_EN:
  - Defined: N=7. Position 6 is a blank frame; `rot_sel`=3'b110 drives the mux default code, so all digits are blanked. Wraps become 6→0 forward and 0→6 backward.
  - Undefined: N=6, and `rot_sel` is never 6 or 7.

## Structure
- Package `rotate_seq_pkg`:
  - Localparams for the position count (6/7, selected by the macro), max index, and select width 3.
  - State enum {RUN, PAUSE}.
- Sub-module `key_debounce`, instantiated three times. It contains the synchronizer, debounce counter and press-edge pulse, is parameterized by DEBOUNCE_CYCLES, and has ports CLOCK_50, resetn, key_n, level, press.

## Test plan
Parameters TICK_DIV=4, DEBOUNCE_CYCLES=3, keys idle high unless stated.
- Reset then free-run 30 cycles: `rot_sel` steps 0,1,2,3,4,5,0 with a `tick` every 4 cycles; `running`=1 and `dir`=0 throughout.
- Pause press, held low 10 cycles: `running`=0 exactly 6 edges after the first low sample; no further `tick`.
  - Two step presses then: `rot_sel` +2, one `tick` per press.
- From `rot_sel`=0, dir press then one tick: `dir`=1 and `rot_sel`=5 (4 without the macro? no — 5 without, 6 with ROTATE_SEQ_BLANK_EN).
- Bouncy key (low 2, high 1, low 2 cycles, then released): no event, outputs unchanged.
- Step and dir pressed on the same cycle while paused at `rot_sel`=2, `dir`=0: `dir`=1 and `rot_sel`=1 on the same edge.
- resetn pulsed low while at `rot_sel`=4, paused, `dir`=1: all outputs return to reset values asynchronously; free-run resumes from 0.

Source files
------------

// File: rtl/rotate_seq_pkg.sv
// Shared types and constants for the rotating-message sequencer.
// Define ROTATE_SEQ_BLANK_EN to add a seventh, all-blank position to the rotation.
package rotate_seq_pkg;

  localparam int SEL_W = 3;
`ifdef ROTATE_SEQ_BLANK_EN
  localparam int NUM_POS = 7;
`else
  localparam int NUM_POS = 6;
`endif
  localparam int MAX_IDX = NUM_POS - 1;
  localparam logic [SEL_W-1:0] MAX_SEL = SEL_W'(MAX_IDX);

  typedef enum logic {
    RUN   = 1'b0,
    PAUSE = 1'b1
  } seq_state_e;

  // Modulo-NUM_POS step; backward=1 decrements with 0 wrapping to MAX_SEL.
  function automatic logic [SEL_W-1:0] next_pos(input logic [SEL_W-1:0] pos,
                                                 input logic backward);
    if (backward) begin
      return (pos == '0) ? MAX_SEL : pos - 1'b1;
    end
    return (pos == MAX_SEL) ? '0 : pos + 1'b1;
  endfunction

endpackage

// File: rtl/rotate_sequencer_if.sv
// Key inputs and rotation-select outputs of the rotate sequencer.
interface rotate_sequencer_if;
  import rotate_seq_pkg::*;

  logic             key_pause_n;
  logic             key_step_n;
  logic             key_dir_n;
  logic [SEL_W-1:0] rot_sel;
  logic             tick;
  logic             running;
  logic             dir;

  modport master (
    input  key_pause_n, key_step_n, key_dir_n,
    output rot_sel, tick, running, dir
  );

  modport slave (
    output key_pause_n, key_step_n, key_dir_n,
    input  rot_sel, tick, running, dir
  );

endinterface

// File: rtl/rotate_sequencer_key_debounce.sv
// Push-button conditioning: 2-flop synchronizer, stability debouncer and
// a one-cycle press pulse on the debounced high-to-low transition.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic CLOCK_50,
  input  logic resetn,
  input  logic key_n,
  output logic level,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // The press pulse is registered on the same edge the level flips, so it
  // is seen by the action register exactly one edge later.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync2;
          cnt   <= '0;
          press <= ~sync2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/rotate_sequencer.sv
// Timed, key-controlled rotation select for the 6-digit message display.
// Define ROTATE_SEQ_BLANK_EN to include the blank frame (select 6) in the rotation.
module rotate_sequencer
  import rotate_seq_pkg::*;
#(
  parameter int TICK_DIV        = 50000000,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  rotate_sequencer_if.master  bus
);

  localparam int PRESC_W = $clog2(TICK_DIV);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

  seq_state_e         state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [SEL_W-1:0]   rot_sel_q, rot_sel_d;
  logic               tick_q, tick_d;
  logic               dir_q, dir_d;
  logic               wrap, advance;
  logic               pause_ev, step_ev, dir_ev;
  logic [2:0]         unused_level;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .key_n    (bus.key_pause_n),
    .level    (unused_level[0]),
    .press    (pause_ev)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .key_n    (bus.key_step_n),
    .level    (unused_level[1]),
    .press    (step_ev)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dir (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .key_n    (bus.key_dir_n),
    .level    (unused_level[2]),
    .press    (dir_ev)
  );

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q   <= RUN;
      presc_q   <= '0;
      rot_sel_q <= '0;
      tick_q    <= 1'b0;
      dir_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      rot_sel_q <= rot_sel_d;
      tick_q    <= tick_d;
      dir_q     <= dir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (pause_ev) begin
      state_d = (state_q == RUN) ? PAUSE : RUN;
    end
  end

  // Direction is resolved before the advance so a coincident dir press
  // steers the same-cycle step or wrap.
  always_comb begin
    dir_d   = dir_q ^ dir_ev;
    wrap    = (state_q == RUN) && (presc_q == PRESC_LAST);
    advance = wrap || ((state_q == PAUSE) && step_ev);
    presc_d = '0;
    if ((state_q == RUN) && !wrap && !pause_ev) begin
      presc_d = presc_q + 1'b1;
    end
    rot_sel_d = advance ? next_pos(rot_sel_q, dir_d) : rot_sel_q;
    tick_d    = advance;
  end

  assign bus.rot_sel = rot_sel_q;
  assign bus.tick    = tick_q;
  assign bus.running = (state_q == RUN);
  assign bus.dir     = dir_q;

endmodule

// File: tb/tb_rotate_sequencer.sv
// Self-checking bench for rotate_sequencer: directed key scenarios plus random
// key activity, compared every cycle against a behavioural model.
module tb_rotate_sequencer;

  localparam int TICK_DIV = 4;
  localparam int DEB      = 3;
`ifdef ROTATE_SEQ_BLANK_EN
  localparam int N = 7;
`else
  localparam int N = 6;
`endif

  logic clk;
  logic resetn;
  int   errors = 0;
  int   checks = 0;
  int   tick_seen = 0;

  rotate_sequencer_if bus();

  rotate_sequencer #(.TICK_DIV(TICK_DIV), .DEBOUNCE_CYCLES(DEB)) dut (
    .CLOCK_50 (clk),
    .resetn   (resetn),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: key index 0 = pause, 1 = step, 2 = dir.
  int m_pos, m_presc;
  bit m_dir, m_run, m_tick;
  bit s1 [3];
  bit s2 [3];
  bit lvl [3];
  int cnt [3];
  bit ev [3];
  bit [2:0] cur_raw;

  function void model_reset();
    m_pos = 0; m_presc = 0; m_dir = 0; m_run = 1; m_tick = 0;
    for (int k = 0; k < 3; k++) begin
      s1[k] = 1; s2[k] = 1; lvl[k] = 1; cnt[k] = 0; ev[k] = 0;
    end
  endfunction

  function void model_step();
    bit adv;
    adv = 0;
    m_tick = 0;
    if (ev[2]) m_dir = !m_dir;
    if (m_run) begin
      if (m_presc == TICK_DIV - 1) begin
        adv = 1;
        m_presc = 0;
      end else begin
        m_presc++;
      end
      if (ev[0]) begin
        m_run = 0;
        m_presc = 0;
      end
    end else begin
      if (ev[1]) adv = 1;
      if (ev[0]) m_run = 1;
    end
    if (adv) begin
      m_pos  = m_dir ? (m_pos + N - 1) % N : (m_pos + 1) % N;
      m_tick = 1;
    end
    for (int k = 0; k < 3; k++) begin
      ev[k] = 0;
      if (s2[k] != lvl[k]) begin
        cnt[k]++;
        if (cnt[k] == DEB) begin
          lvl[k] = s2[k];
          cnt[k] = 0;
          ev[k]  = (lvl[k] == 0);
        end
      end else begin
        cnt[k] = 0;
      end
      s2[k] = s1[k];
      s1[k] = cur_raw[k];
    end
  endfunction

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Called at a negedge: drives keys, lets one rising edge pass, then compares.
  task automatic applyStimulus(input logic p, input logic s, input logic d);
    bus.key_pause_n = p;
    bus.key_step_n  = s;
    bus.key_dir_n   = d;
    cur_raw = {d, s, p};
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (bus.tick) tick_seen++;
    checkOutput("rot_sel", int'(bus.rot_sel), m_pos);
    checkOutput("tick",    int'(bus.tick),    int'(m_tick));
    checkOutput("running", int'(bus.running), int'(m_run));
    checkOutput("dir",     int'(bus.dir),     int'(m_dir));
  endtask

  task automatic pressKeys(input logic [2:0] mask, input int low, input int high);
    for (int i = 0; i < low; i++) applyStimulus(!mask[0], !mask[1], !mask[2]);
    for (int i = 0; i < high; i++) applyStimulus(1'b1, 1'b1, 1'b1);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_rot"},  int'(bus.rot_sel), 0);
    checkOutput({tag, "_tick"}, int'(bus.tick),    0);
    checkOutput({tag, "_run"},  int'(bus.running), 1);
    checkOutput({tag, "_dir"},  int'(bus.dir),     0);
  endtask

  int lat;
  int start_pos;
  int guard;
  int hold [3];
  bit [2:0] raw;

  initial begin
    resetn = 1'b1;
    bus.key_pause_n = 1'b1;
    bus.key_step_n  = 1'b1;
    bus.key_dir_n   = 1'b1;
    cur_raw = 3'b111;
    model_reset();
    #1 resetn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkReset("reset");
    resetn = 1'b1;

    // Free run: ticks every TICK_DIV cycles, forward.
    tick_seen = 0;
    for (int i = 0; i < 30; i++) applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("freerun_ticks", tick_seen, 7);

    // Pause press latency: first low sample at edge 1, pause at edge DEB+3.
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1);
      if (!bus.running && lat == 0) lat = i;
    end
    checkOutput("pause_latency", lat, DEB + 3);
    tick_seen = 0;
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("paused_no_tick", tick_seen, 0);

    // Two step presses while paused.
    start_pos = m_pos;
    tick_seen = 0;
    pressKeys(3'b010, 6, 8);
    pressKeys(3'b010, 6, 8);
    checkOutput("step_ticks", tick_seen, 2);
    checkOutput("step_pos", int'(bus.rot_sel), (start_pos + 2) % N);

    // Walk to position 2 (forward), then step+dir together.
    guard = 0;
    while (m_pos != 2 && guard < 2 * N) begin
      pressKeys(3'b010, 6, 8);
      guard++;
    end
    checkOutput("reach_pos2", m_pos, 2);
    pressKeys(3'b110, 6, 8);
    checkOutput("stepdir_rot", int'(bus.rot_sel), 1);
    checkOutput("stepdir_dir", int'(bus.dir), 1);

    // Back to 0 (backward), dir press to forward, dir press again then one step.
    pressKeys(3'b010, 6, 8);
    checkOutput("at_zero", int'(bus.rot_sel), 0);
    pressKeys(3'b100, 6, 8);
    checkOutput("dir_fwd", int'(bus.dir), 0);
    pressKeys(3'b100, 6, 8);
    pressKeys(3'b010, 6, 8);
    checkOutput("wrap_back_rot", int'(bus.rot_sel), N - 1);
    checkOutput("wrap_back_dir", int'(bus.dir), 1);

    // Bouncy step key never stays low long enough.
    tick_seen = 0;
    start_pos = m_pos;
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("bounce_ticks", tick_seen, 0);
    checkOutput("bounce_pos", int'(bus.rot_sel), start_pos);

    // Walk backward to position 4, then asynchronous reset mid-cycle.
    guard = 0;
    while (m_pos != 4 && guard < 2 * N) begin
      pressKeys(3'b010, 6, 8);
      guard++;
    end
    checkOutput("reach_pos4", int'(bus.rot_sel), 4);
    #2 resetn = 1'b0;
    #1 checkReset("async_reset");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    tick_seen = 0;
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("resume_ticks", tick_seen, 2);
    checkOutput("resume_pos", int'(bus.rot_sel), 2);

    // Random key activity against the model.
    raw = 3'b111;
    for (int k = 0; k < 3; k++) hold[k] = $urandom_range(1, 20);
    for (int c = 0; c < 800; c++) begin
      for (int k = 0; k < 3; k++) begin
        if (hold[k] == 0) begin
          raw[k]  = ~raw[k];
          hold[k] = raw[k] ? $urandom_range(1, 25) : $urandom_range(1, 10);
        end
        hold[k]--;
      end
      applyStimulus(raw[0], raw[1], raw[2]);
    end
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
